// File: rtl/fdiv_iter.sv
// fdiv_iter: iterative single-precision (binary32) floating-point divider.
// Restoring division, one quotient bit per clock and one operation in flight.
// The issue logic stalls on ready. A tag travels with the operation.
// Rounding truncates toward zero. Denormal inputs are treated as zero.
module fdiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adata,
  input  logic [31:0] bdata,
  input  logic        flag_in,
  input  logic [4:0]  address_in,
  output logic        ready,
  output logic [31:0] result,
  output logic        flag_out,
  output logic [4:0]  address_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  localparam logic [4:0] LAST_BIT = 5'd24;  // 25 quotient bits, counted 24 down to 0

  state_t state, state_next;

  // Operation context latched at issue
  logic        s_q;
  logic [7:0]  ea_q, eb_q;
  logic        za_q, zb_q;
  logic [4:0]  addr_q;
  logic [23:0] mb_q;

  // Division working registers
  logic [4:0]  count;
  logic [25:0] r_q;
  logic [24:0] q_q;

  // Control decode
  logic accept;
  logic div_step;
  logic load_result;

  // Datapath combinational signals
  logic        r_ge;
  logic [25:0] r_sub;
  logic [25:0] r_next;
  logic signed [9:0] e_s;
  logic signed [9:0] exp_s;
  logic [22:0] mant;
  logic [31:0] packed_res;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking (<=) so every register
    // samples the pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> DIV -> NORM -> IDLE
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (flag_in) state_next = DIV;
      DIV:     if (count == 5'd0) state_next = NORM;
      NORM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode from the current state
  always_comb begin
    ready       = 1'b0;
    accept      = 1'b0;
    div_step    = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = flag_in;
      end
      DIV:     div_step    = 1'b1;
      NORM:    load_result = 1'b1;
      default: ready       = 1'b0;
    endcase
  end

  // One restoring-division step: subtract when possible, then shift
  always_comb begin
    r_ge   = (r_q >= {2'b00, mb_q});
    r_sub  = r_ge ? (r_q - {2'b00, mb_q}) : r_q;
    r_next = r_sub << 1;
  end

  // Operand capture at issue and the quotient iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 1'b0;
      ea_q   <= 8'd0;
      eb_q   <= 8'd0;
      za_q   <= 1'b0;
      zb_q   <= 1'b0;
      addr_q <= 5'd0;
      mb_q   <= 24'd0;
      count  <= 5'd0;
      r_q    <= 26'd0;
      q_q    <= 25'd0;
    end else if (accept) begin
      s_q    <= adata[31] ^ bdata[31];
      ea_q   <= adata[30:23];
      eb_q   <= bdata[30:23];
      za_q   <= (adata[30:23] == 8'd0);
      zb_q   <= (bdata[30:23] == 8'd0);
      addr_q <= address_in;
      mb_q   <= {1'b1, bdata[22:0]};
      r_q    <= {2'b01, adata[22:0]};
      q_q    <= 25'd0;
      count  <= LAST_BIT;
    end else if (div_step) begin
      r_q   <= r_next;
      q_q   <= {q_q[23:0], r_ge};
      count <= count - 5'd1;
    end
  end

  // Exponent, normalisation and special-case selection of the packed result
  always_comb begin
    e_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (q_q[24]) begin
      exp_s = e_s;
      mant  = q_q[23:1];
    end else begin
      exp_s = e_s - 10'sd1;
      mant  = q_q[22:0];
    end

    if (za_q)                     packed_res = 32'h0000_0000;
    else if (zb_q)                packed_res = {s_q, 8'hFF, 23'd0};
    else if (exp_s >= 10'sd255)   packed_res = {s_q, 8'hFF, 23'd0};
    else if (exp_s <= 10'sd0)     packed_res = 32'h0000_0000;
    else                          packed_res = {s_q, exp_s[7:0], mant};
  end

  // Completion registers: result/address hold, flag_out pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      result      <= 32'd0;
      flag_out    <= 1'b0;
      address_out <= 5'd0;
    end else begin
      flag_out <= load_result;
      if (load_result) begin
        result      <= packed_res;
        address_out <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: directed self-checking bench for the iterative FP divider.
module tb_fdiv_iter;

  logic        clk;
  logic        rst;
  logic [31:0] adata;
  logic [31:0] bdata;
  logic        flag_in;
  logic [4:0]  address_in;
  logic        ready;
  logic [31:0] result;
  logic        flag_out;
  logic [4:0]  address_out;

  int total = 0;
  int bad   = 0;

  fdiv_iter dut (
    .clk         (clk),
    .rst         (rst),
    .adata       (adata),
    .bdata       (bdata),
    .flag_in     (flag_in),
    .address_in  (address_in),
    .ready       (ready),
    .result      (result),
    .flag_out    (flag_out),
    .address_out (address_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs settle before the bench looks at them.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait up to 40 edges for its completion.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] addr, input logic [31:0] exp_res);
    int first_at;
    int pulses;
    logic [31:0] res_at;
    logic [4:0]  addr_at;
    first_at = -1;
    pulses   = 0;
    res_at   = 32'hDEAD_BEEF;
    addr_at  = 5'h1F;
    adata      = a;
    bdata      = b;
    address_in = addr;
    flag_in    = 1'b1;
    tick();
    flag_in = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (flag_out === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          res_at   = result;
          addr_at  = address_out;
        end
      end
    end
    check({tag, " latency"}, first_at, 26);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " result"}, res_at, exp_res);
    check({tag, " addr"}, {27'd0, addr_at}, {27'd0, addr});
  endtask

  initial begin
    int rdy_high;
    int pulses;
    int first_at;
    logic [31:0] res_at;
    logic [4:0]  addr_at;

    rst        = 1'b1;
    adata      = 32'd0;
    bdata      = 32'd0;
    flag_in    = 1'b0;
    address_in = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 1. Reset state then a basic divide 6/2 = 3
    check("rst ready",    {31'd0, ready},    32'd1);
    check("rst flag_out", {31'd0, flag_out}, 32'd0);
    check("rst result",   result,            32'd0);
    check("rst addr",     {27'd0, address_out}, 32'd0);
    run_op("6/2", 32'h40C0_0000, 32'h4000_0000, 5'd5, 32'h4040_0000);

    // 2. Ordinary quotients, truncation and sign
    run_op("1/3",    32'h3F80_0000, 32'h4040_0000, 5'd3,  32'h3EAA_AAAA);
    run_op("-1/2",   32'hBF80_0000, 32'h4000_0000, 5'd7,  32'hBF00_0000);
    run_op("1.5/1",  32'h3FC0_0000, 32'h3F80_0000, 5'd9,  32'h3FC0_0000);

    // 3. Zero operands
    run_op("0/5",    32'h0000_0000, 32'h40A0_0000, 5'd10, 32'h0000_0000);
    run_op("1/0",    32'h3F80_0000, 32'h0000_0000, 5'd11, 32'h7F80_0000);
    run_op("-1/0",   32'hBF80_0000, 32'h0000_0000, 5'd12, 32'hFF80_0000);

    // 4. Exponent range limits
    run_op("ovf",    32'h7F00_0000, 32'h0080_0000, 5'd13, 32'h7F80_0000);
    run_op("unf",    32'h0080_0000, 32'h7F00_0000, 5'd14, 32'h0000_0000);

    // 5. Busy period: B pulses while A runs are ignored; B reissued afterwards
    adata      = 32'h40C0_0000;  // A: 6/2, addr 1
    bdata      = 32'h4000_0000;
    address_in = 5'd1;
    flag_in    = 1'b1;
    tick();                      // edge N
    rdy_high = 0;
    pulses   = 0;
    first_at = -1;
    res_at   = 32'hDEAD_BEEF;
    addr_at  = 5'h1F;
    adata      = 32'h3F80_0000;  // B: 1/3, addr 2
    bdata      = 32'h4040_0000;
    address_in = 5'd2;
    for (int i = 1; i <= 26; i++) begin
      flag_in = (i == 1 || i == 13);
      if (ready !== 1'b0) rdy_high++;
      tick();                    // edge N+i
      if (flag_out === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          res_at   = result;
          addr_at  = address_out;
        end
      end
    end
    flag_in = 1'b0;
    check("busy ready low",  rdy_high, 0);
    check("busy pulses",     pulses,   1);
    check("busy latency",    first_at, 26);
    check("busy A result",   res_at,   32'h4040_0000);
    check("busy A addr",     {27'd0, addr_at}, 32'd1);
    check("busy ready back", {31'd0, ready}, 32'd1);
    flag_in = 1'b1;              // B reissued at edge N+27
    tick();
    flag_in = 1'b0;
    check("A pulse ends", {31'd0, flag_out}, 32'd0);
    pulses   = 0;
    first_at = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (flag_out === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = i;
          res_at   = result;
          addr_at  = address_out;
        end
      end
    end
    check("B latency", first_at, 26);
    check("B pulses",  pulses,   1);
    check("B result",  res_at,   32'h3EAA_AAAA);
    check("B addr",    {27'd0, addr_at}, 32'd2);

    // 6. Reset mid-operation abandons the op
    adata      = 32'h3FC0_0000;
    bdata      = 32'h3F80_0000;
    address_in = 5'd6;
    flag_in    = 1'b1;
    tick();                      // edge N
    flag_in = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    rst = 1'b1;
    tick();                      // edge N+10
    rst = 1'b0;
    check("mid rst ready",  {31'd0, ready},       32'd1);
    check("mid rst result", result,               32'd0);
    check("mid rst addr",   {27'd0, address_out}, 32'd0);
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (flag_out === 1'b1) pulses++;
    end
    check("abandoned op pulses", pulses, 0);
    run_op("post rst 6/2", 32'h40C0_0000, 32'h4000_0000, 5'd4, 32'h4040_0000);

    // Reset and issue on the same edge: reset wins
    rst     = 1'b1;
    flag_in = 1'b1;
    tick();
    rst     = 1'b0;
    flag_in = 1'b0;
    check("rst+issue ready", {31'd0, ready}, 32'd1);
    tick();
    check("rst+issue still idle", {31'd0, ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
